// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and parameter defaults for the memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   localparam int MEM_LAT_DEF  = 1;
   localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_prio_select.sv
// Winner selection: CPU has fixed priority unless DMA has been passed over
// MAX_WAIT times in a row, in which case DMA is forced through.
module arb_prio_select
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic       cpu_req,
   input  logic       dma_req,
   input  logic [3:0] starve_cnt,
   output logic       winner,
   output logic       valid
);

   // Combinational priority pick with starvation override.
   always_comb begin
      valid  = cpu_req | dma_req;
      winner = OWN_CPU;
      if (dma_req && (!cpu_req || (starve_cnt == 4'(MAX_WAIT)))) begin
         winner = OWN_DMA;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the unified instruction/data memory.
//
// state  | meaning
// S_IDLE | no access in flight; arbitrate, grant and strobe memory this cycle
// S_WAIT | access in flight; lat_cnt counts down, done pulses at zero
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MEM_LAT  = MEM_LAT_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [DW-1:0] cpu_wd,
   output logic          cpu_gnt,
   output logic          cpu_done,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_adr,
   input  logic [DW-1:0] dma_wd,
   output logic          dma_gnt,
   output logic          dma_done,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   output logic          busy
);

   localparam logic [2:0] LAT_INIT  = 3'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_MX = 4'(MAX_WAIT);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic [2:0] lat_cnt_q, lat_cnt_d;
   logic [3:0] starve_cnt_q, starve_cnt_d;
   logic       win;
   logic       win_valid;

   arb_prio_select #(
      .MAX_WAIT (MAX_WAIT)
   ) u_sel (
      .cpu_req    (cpu_req),
      .dma_req    (dma_req),
      .starve_cnt (starve_cnt_q),
      .winner     (win),
      .valid      (win_valid)
   );

   // State, owner and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_CPU;
         lat_cnt_q    <= '0;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         lat_cnt_q    <= lat_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   // Next state and outputs. Reset gates every strobe so an access cut off
   // mid-flight never reports done.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      lat_cnt_d    = lat_cnt_q;
      starve_cnt_d = starve_cnt_q;
      cpu_gnt      = 1'b0;
      cpu_done     = 1'b0;
      cpu_rdata    = '0;
      dma_gnt      = 1'b0;
      dma_done     = 1'b0;
      dma_rdata    = '0;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_adr      = '0;
      mem_wd       = '0;
      busy         = 1'b0;

      if (!reset) begin
         unique case (state_q)
            S_IDLE: begin
               if (win_valid) begin
                  mem_en    = 1'b1;
                  busy      = 1'b1;
                  owner_d   = win;
                  lat_cnt_d = LAT_INIT;
                  state_d   = S_WAIT;
                  if (win == OWN_DMA) begin
                     dma_gnt = 1'b1;
                     mem_we  = dma_we;
                     mem_adr = dma_adr;
                     mem_wd  = dma_wd;
                  end else begin
                     cpu_gnt = 1'b1;
                     mem_we  = cpu_we;
                     mem_adr = cpu_adr;
                     mem_wd  = cpu_wd;
                  end
               end
               // cpu_gnt in the else branch implies dma_req was pending
               if (dma_gnt || !dma_req) begin
                  starve_cnt_d = '0;
               end else if (cpu_gnt && (starve_cnt_q != STARVE_MX)) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
            S_WAIT: begin
               busy = 1'b1;
               if (lat_cnt_q == 3'd0) begin
                  state_d = S_IDLE;
                  if (owner_q == OWN_DMA) begin
                     dma_done  = 1'b1;
                     dma_rdata = mem_rd;
                  end else begin
                     cpu_done  = 1'b1;
                     cpu_rdata = mem_rd;
                  end
               end else begin
                  lat_cnt_d = lat_cnt_q - 3'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      cpu_stall = cpu_req & ~cpu_done;
   end

endmodule
